// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: shared definitions for the iterative ALU.
//
// Holds the core's existing `define-style op codes and PSW bit positions
// (guarded so other core files can carry the same block), typed localparam
// mirrors of them, and the controller state type.
//
// No ports (package).

`ifndef ALU_DEFS
`define ALU_DEFS
`define ALU_OP_ADD  4'd0
`define ALU_OP_ADDC 4'd1
`define ALU_OP_SUBB 4'd2
`define ALU_OP_INC  4'd3
`define ALU_OP_DEC  4'd4
`define ALU_OP_MUL  4'd5
`define ALU_OP_DIV  4'd6
`define ALU_OP_ANL  4'd7
`define ALU_OP_ORL  4'd8
`define ALU_OP_XRL  4'd9
`define ALU_OP_CLR  4'd10
`define ALU_OP_CPL  4'd11
`define ALU_OP_MOV  4'd12
`define ALU_OP_SETB 4'd13
`define PSW_CY 7
`define PSW_AC 6
`define PSW_OV 2
`define PSW_P  0
`endif

package alu_iter_pkg;

  localparam logic [3:0] OP_ADD  = `ALU_OP_ADD;
  localparam logic [3:0] OP_ADDC = `ALU_OP_ADDC;
  localparam logic [3:0] OP_SUBB = `ALU_OP_SUBB;
  localparam logic [3:0] OP_INC  = `ALU_OP_INC;
  localparam logic [3:0] OP_DEC  = `ALU_OP_DEC;
  localparam logic [3:0] OP_MUL  = `ALU_OP_MUL;
  localparam logic [3:0] OP_DIV  = `ALU_OP_DIV;
  localparam logic [3:0] OP_ANL  = `ALU_OP_ANL;
  localparam logic [3:0] OP_ORL  = `ALU_OP_ORL;
  localparam logic [3:0] OP_XRL  = `ALU_OP_XRL;
  localparam logic [3:0] OP_CLR  = `ALU_OP_CLR;
  localparam logic [3:0] OP_CPL  = `ALU_OP_CPL;
  localparam logic [3:0] OP_MOV  = `ALU_OP_MOV;
  localparam logic [3:0] OP_SETB = `ALU_OP_SETB;

  localparam int CY_BIT = `PSW_CY;
  localparam int AC_BIT = `PSW_AC;
  localparam int OV_BIT = `PSW_OV;
  localparam int P_BIT  = `PSW_P;

  // ST_FIN is the cycle in which done is high; a new start is accepted there.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIN
  } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_muldiv_iter: iterative multiply / restoring-divide engine.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   go           load operands and start DATA_W iteration steps
//   mode         0 = MUL (shift-add), 1 = DIV (restoring subtract), sampled on go
//   a_data       multiplicand / dividend
//   b_data       multiplier / divisor (must be non-zero for DIV)
//   fin          high during the last iteration step
//   lo, hi       word values produced by the step taken this cycle; on fin
//                they are the final product {hi,lo} or quotient lo / remainder hi
//
// The outputs are the combinational next-step values so that the
// controller can register the final result on the same edge as the last
// step, giving a DATA_W+1 cycle total latency.

module alu_muldiv_iter
  import alu_iter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              mode,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              fin,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [CW-1:0]     count;
  logic              mode_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] b_q;

  logic [DATA_W:0] add_sum;
  logic [DATA_W:0] rem_shift;
  logic [DATA_W:0] rem_diff;

  // One step of either algorithm.
  // MUL: conditionally add B into the high word, then shift {carry,hi,lo}
  //      right by one; after DATA_W steps {hi,lo} is the full product.
  // DIV: shift the next dividend bit into the partial remainder and try to
  //      subtract B; the remainder is always < B so the shifted value fits
  //      in DATA_W+1 bits and bit DATA_W of the difference is the sign.
  always_comb begin
    add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_shift = {hi_q, lo_q[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    if (mode_q) begin
      if (!rem_diff[DATA_W]) begin
        hi = rem_diff[DATA_W-1:0];
        lo = {lo_q[DATA_W-2:0], 1'b1};
      end else begin
        hi = rem_shift[DATA_W-1:0];
        lo = {lo_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi = add_sum[DATA_W:1];
      lo = {add_sum[0], lo_q[DATA_W-1:1]};
    end
  end

  assign fin = (count == CW'(1));

  // Operand load on go, then one step per cycle while the counter runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      mode_q <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
      b_q    <= '0;
    end else if (go) begin
      count  <= CW'(DATA_W);
      mode_q <= mode;
      lo_q   <= a_data;
      hi_q   <= '0;
      b_q    <= b_data;
    end else if (count != '0) begin
      count <= count - CW'(1);
      lo_q  <= lo;
      hi_q  <= hi;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: registered 8051-style ALU with iterative MUL/DIV.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, accepted when busy=0 (including the done cycle)
//   alu_op       operation code (see alu_iter_pkg)
//   a_data       operand A (ACC)
//   b_data       operand B
//   psw_in       current PSW, sampled on accept
//   busy         high while a MUL/DIV is iterating
//   done         one-cycle pulse, results valid in the same cycle
//   ans          result / MUL low word / DIV quotient
//   ans_hi       MUL high word / DIV remainder, zero for other ops
//   psw_out      updated PSW (CY, AC, OV, P at fixed bit positions)

module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PSW_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [PSW_W-1:0]  psw_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ans,
  output logic [DATA_W-1:0] ans_hi,
  output logic [PSW_W-1:0]  psw_out
);

  localparam int HB = DATA_W / 2;

  state_t             state;
  logic               is_div_q;
  logic [PSW_W-1:0]   psw_q;

  logic               add_cin;
  logic               sub_cin;
  logic [DATA_W:0]    sum_full;
  logic [DATA_W:0]    diff_full;
  logic [DATA_W-1:0]  sc_ans;
  logic [DATA_W-1:0]  sc_hi;
  logic [PSW_W-1:0]   sc_psw;
  logic               launch_iter;

  logic               md_go;
  logic               md_fin;
  logic [DATA_W-1:0]  md_lo;
  logic [DATA_W-1:0]  md_hi;
  logic [PSW_W-1:0]   md_psw;

  // Single-cycle datapath and flags, computed straight from the inputs so
  // the result can be registered on the accept edge.
  // AC is the carry/borrow into bit HB, recovered as sum ^ a ^ b at that bit.
  always_comb begin
    add_cin   = (alu_op == OP_ADDC) & psw_in[CY_BIT];
    sub_cin   = psw_in[CY_BIT];
    sum_full  = {1'b0, a_data} + {1'b0, b_data} + {{DATA_W{1'b0}}, add_cin};
    diff_full = {1'b0, a_data} - {1'b0, b_data} - {{DATA_W{1'b0}}, sub_cin};
    sc_ans    = a_data;
    sc_hi     = '0;
    sc_psw    = psw_in;
    case (alu_op)
      OP_ADD, OP_ADDC: begin
        sc_ans         = sum_full[DATA_W-1:0];
        sc_psw[CY_BIT] = sum_full[DATA_W];
        sc_psw[AC_BIT] = sum_full[HB] ^ a_data[HB] ^ b_data[HB];
        sc_psw[OV_BIT] = (a_data[DATA_W-1] == b_data[DATA_W-1]) &&
                         (sum_full[DATA_W-1] != a_data[DATA_W-1]);
      end
      OP_SUBB: begin
        sc_ans         = diff_full[DATA_W-1:0];
        sc_psw[CY_BIT] = diff_full[DATA_W];
        sc_psw[AC_BIT] = diff_full[HB] ^ a_data[HB] ^ b_data[HB];
        sc_psw[OV_BIT] = (a_data[DATA_W-1] != b_data[DATA_W-1]) &&
                         (diff_full[DATA_W-1] != a_data[DATA_W-1]);
      end
      OP_INC:  sc_ans = a_data + DATA_W'(1);
      OP_DEC:  sc_ans = a_data - DATA_W'(1);
      OP_MUL:  sc_ans = a_data;
      OP_DIV: begin
        // Only the divide-by-zero case completes here.
        sc_ans         = '1;
        sc_hi          = a_data;
        sc_psw[CY_BIT] = 1'b0;
        sc_psw[OV_BIT] = 1'b1;
      end
      OP_ANL:  sc_ans = a_data & b_data;
      OP_ORL:  sc_ans = a_data | b_data;
      OP_XRL:  sc_ans = a_data ^ b_data;
      OP_CLR:  sc_ans = '0;
      OP_CPL:  sc_ans = ~a_data;
      OP_MOV:  sc_ans = b_data;
      OP_SETB: sc_ans = DATA_W'(1);
      default: sc_ans = a_data;
    endcase
    sc_psw[P_BIT] = ^sc_ans;
  end

  // MUL always iterates; DIV iterates unless the divisor is zero.
  assign launch_iter = (alu_op == OP_MUL) ||
                       ((alu_op == OP_DIV) && (b_data != '0));

  assign md_go = start && (state != ST_ITER) && launch_iter;

  // Flags for a finished MUL/DIV, built on the PSW latched at accept.
  always_comb begin
    md_psw         = psw_q;
    md_psw[CY_BIT] = 1'b0;
    md_psw[OV_BIT] = is_div_q ? 1'b0 : (md_hi != '0);
    md_psw[P_BIT]  = ^md_lo;
  end

  alu_muldiv_iter #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (md_go),
    .mode   (alu_op == OP_DIV),
    .a_data (a_data),
    .b_data (b_data),
    .fin    (md_fin),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // Controller. Results are registered on the edge that enters ST_FIN, so
  // done and the outputs appear together; ST_FIN also accepts a new start
  // for back-to-back operation. A start during ST_ITER is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ans      <= '0;
      ans_hi   <= '0;
      psw_out  <= '0;
      is_div_q <= 1'b0;
      psw_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_FIN: begin
          if (start) begin
            is_div_q <= (alu_op == OP_DIV);
            psw_q    <= psw_in;
            if (launch_iter) begin
              state <= ST_ITER;
              busy  <= 1'b1;
            end else begin
              state   <= ST_FIN;
              done    <= 1'b1;
              ans     <= sc_ans;
              ans_hi  <= sc_hi;
              psw_out <= sc_psw;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ITER: begin
          if (md_fin) begin
            state   <= ST_FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            ans     <= md_lo;
            ans_hi  <= md_hi;
            psw_out <= md_psw;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: self-checking bench for alu_iter (8-bit instance plus a
// 16-bit instance for the wide MUL case). Expected results are pushed to a
// scoreboard queue when a request is driven and popped when done appears.

module tb_alu_iter;
  import alu_iter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] alu_op;
  logic [7:0] a_data, b_data, psw_in;
  logic       busy, done;
  logic [7:0] ans, ans_hi, psw_out;

  logic        start16;
  logic [3:0]  alu_op16;
  logic [15:0] a16, b16;
  logic [7:0]  psw16;
  logic        busy16, done16;
  logic [15:0] ans16, ans_hi16;
  logic [7:0]  psw_out16;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] psw;
    logic [7:0] ans;
    logic [7:0] hi;
    logic [7:0] psw_exp;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] ans;
    logic [7:0] hi;
    logic [7:0] psw;
    int         lat;
  } exp_t;

  vec_t vecs[21];
  exp_t sb[$];

  alu_iter #(.DATA_W(8), .PSW_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .alu_op  (alu_op),
    .a_data  (a_data),
    .b_data  (b_data),
    .psw_in  (psw_in),
    .busy    (busy),
    .done    (done),
    .ans     (ans),
    .ans_hi  (ans_hi),
    .psw_out (psw_out)
  );

  alu_iter #(.DATA_W(16), .PSW_W(8)) dut16 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start16),
    .alu_op  (alu_op16),
    .a_data  (a16),
    .b_data  (b16),
    .psw_in  (psw16),
    .busy    (busy16),
    .done    (done16),
    .ans     (ans16),
    .ans_hi  (ans_hi16),
    .psw_out (psw_out16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one request at a falling edge and record what it must produce.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] psw, input logic [7:0] e_ans,
                               input logic [7:0] e_hi, input logic [7:0] e_psw, input int lat);
    exp_t e;
    @(negedge clk);
    alu_op = op;
    a_data = a;
    b_data = b;
    psw_in = psw;
    start  = 1'b1;
    e.ans = e_ans;
    e.hi  = e_hi;
    e.psw = e_psw;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Wait (bounded) for done, then compare against the oldest expectation.
  task automatic checkOutput(input string tag);
    exp_t e;
    int   cycles;
    bit   got;
    if (sb.size() == 0) begin
      compare({tag, " scoreboard"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) start = 1'b0;
      got = done;
    end
    compare({tag, " done"}, 32'(got), 32'd1);
    if (got) begin
      compare({tag, " latency"}, 32'(cycles), 32'(e.lat));
      compare({tag, " ans"}, 32'(ans), 32'(e.ans));
      compare({tag, " ans_hi"}, 32'(ans_hi), 32'(e.hi));
      compare({tag, " psw"}, 32'(psw_out), 32'(e.psw));
    end
  endtask

  initial begin
    int  cycles;
    bit  got;
    exp_t e;

    //            op       a      b      psw    ans    hi     psw_exp lat
    vecs[0]  = '{OP_ADD,  8'h7F, 8'h01, 8'h00, 8'h80, 8'h00, 8'h45, 1};
    vecs[1]  = '{OP_ADDC, 8'hFF, 8'h00, 8'h80, 8'h00, 8'h00, 8'hC0, 1};
    vecs[2]  = '{OP_SUBB, 8'h00, 8'h01, 8'h80, 8'hFE, 8'h00, 8'hC1, 1};
    vecs[3]  = '{OP_ADD,  8'h0A, 8'h05, 8'h18, 8'h0F, 8'h00, 8'h18, 1};
    vecs[4]  = '{OP_SUBB, 8'h80, 8'h01, 8'h00, 8'h7F, 8'h00, 8'h45, 1};
    vecs[5]  = '{OP_INC,  8'hFF, 8'h00, 8'hC4, 8'h00, 8'h00, 8'hC4, 1};
    vecs[6]  = '{OP_DEC,  8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1};
    vecs[7]  = '{OP_ANL,  8'hF0, 8'h3C, 8'h80, 8'h30, 8'h00, 8'h80, 1};
    vecs[8]  = '{OP_ORL,  8'h0F, 8'h30, 8'h01, 8'h3F, 8'h00, 8'h00, 1};
    vecs[9]  = '{OP_XRL,  8'hAA, 8'h0F, 8'h44, 8'hA5, 8'h00, 8'h44, 1};
    vecs[10] = '{OP_CLR,  8'h55, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1};
    vecs[11] = '{OP_CPL,  8'h0E, 8'h00, 8'h00, 8'hF1, 8'h00, 8'h01, 1};
    vecs[12] = '{OP_MOV,  8'h12, 8'h07, 8'h80, 8'h07, 8'h00, 8'h81, 1};
    vecs[13] = '{OP_SETB, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 1};
    vecs[14] = '{4'd14,   8'h03, 8'h09, 8'hC5, 8'h03, 8'h00, 8'hC4, 1};
    vecs[15] = '{OP_MUL,  8'h50, 8'hA0, 8'h80, 8'h00, 8'h32, 8'h04, 9};
    vecs[16] = '{OP_DIV,  8'hFB, 8'h12, 8'h84, 8'h0D, 8'h11, 8'h01, 9};
    vecs[17] = '{OP_DIV,  8'h37, 8'h00, 8'h80, 8'hFF, 8'h37, 8'h04, 1};
    vecs[18] = '{OP_MUL,  8'h0C, 8'h0B, 8'h44, 8'h84, 8'h00, 8'h40, 9};
    vecs[19] = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'hC0, 1};
    vecs[20] = '{OP_DIV,  8'h07, 8'h09, 8'h00, 8'h00, 8'h07, 8'h00, 9};

    rst_n = 1'b0;
    start = 1'b0; alu_op = '0; a_data = '0; b_data = '0; psw_in = '0;
    start16 = 1'b0; alu_op16 = '0; a16 = '0; b16 = '0; psw16 = '0;
    #2;
    compare("reset busy", 32'(busy), 32'd0);
    compare("reset done", 32'(done), 32'd0);
    compare("reset ans", 32'(ans), 32'd0);
    compare("reset psw", 32'(psw_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].psw,
                    vecs[i].ans, vecs[i].hi, vecs[i].psw_exp, vecs[i].lat);
      checkOutput($sformatf("vec%0d", i));
    end

    // MUL with a start pulse while busy: the extra request must be dropped.
    $display("[TB] start while busy");
    applyStimulus(OP_MUL, 8'h50, 8'hA0, 8'h00, 8'h00, 8'h32, 8'h04, 9);
    e = sb.pop_front();
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        start = 1'b0;
        compare("busy after accept", 32'(busy), 32'd1);
      end
      if (cycles == 3) begin
        alu_op = OP_ADD; a_data = 8'h01; b_data = 8'h01; start = 1'b1;
      end
      if (cycles == 4) start = 1'b0;
      got = done;
    end
    compare("busy-ignore done", 32'(got), 32'd1);
    compare("busy-ignore latency", 32'(cycles), 32'(e.lat));
    compare("busy-ignore ans", 32'(ans), 32'(e.ans));
    compare("busy-ignore ans_hi", 32'(ans_hi), 32'(e.hi));
    compare("busy-ignore psw", 32'(psw_out), 32'(e.psw));
    compare("busy low at done", 32'(busy), 32'd0);
    got = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    compare("no queued done", 32'(got), 32'd0);

    // Back-to-back: start held high across done.
    $display("[TB] back-to-back");
    @(negedge clk);
    alu_op = OP_INC; a_data = 8'hFF; b_data = 8'h00; psw_in = 8'h80; start = 1'b1;
    @(negedge clk);
    compare("b2b inc done", 32'(done), 32'd1);
    compare("b2b inc ans", 32'(ans), 32'h00);
    compare("b2b inc psw", 32'(psw_out), 32'h80);
    alu_op = OP_DEC; a_data = 8'h00;
    @(negedge clk);
    compare("b2b dec done", 32'(done), 32'd1);
    compare("b2b dec ans", 32'(ans), 32'hFF);
    compare("b2b dec psw", 32'(psw_out), 32'h80);
    start = 1'b0;
    @(negedge clk);
    compare("b2b done drops", 32'(done), 32'd0);

    // Reset in the middle of a MUL aborts it with no done afterwards.
    $display("[TB] reset mid-MUL");
    applyStimulus(OP_MUL, 8'h50, 8'hA0, 8'h00, 8'h00, 8'h32, 8'h04, 9);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("abort busy", 32'(busy), 32'd0);
    compare("abort done", 32'(done), 32'd0);
    compare("abort ans", 32'(ans), 32'd0);
    compare("abort ans_hi", 32'(ans_hi), 32'd0);
    compare("abort psw", 32'(psw_out), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    got = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    compare("no done after abort", 32'(got), 32'd0);

    // 16-bit instance: full-scale MUL.
    $display("[TB] 16-bit MUL");
    @(negedge clk);
    alu_op16 = OP_MUL; a16 = 16'hFFFF; b16 = 16'hFFFF; psw16 = 8'h00; start16 = 1'b1;
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) start16 = 1'b0;
      got = done16;
    end
    compare("w16 done", 32'(got), 32'd1);
    compare("w16 latency", 32'(cycles), 32'd17);
    compare("w16 lo", 32'(ans16), 32'h0001);
    compare("w16 hi", 32'(ans_hi16), 32'hFFFE);
    compare("w16 psw", 32'(psw_out16), 32'h05);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
